// File: rtl/counter_seq_ctrl_if.sv
// Command and completion channels of the counter sequencer.
// The master offers commands, the abort pulse and done_ready.
interface counter_seq_ctrl_if #(
   parameter int STEP_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_dir;
   logic [STEP_W-1:0] cmd_steps;
   logic              cmd_stop_on_ovf;
   logic              abort;
   logic              done_valid;
   logic              done_ready;
   logic [1:0]        done_status;
   logic [STEP_W-1:0] done_count;

   modport master (
      output cmd_valid, cmd_dir, cmd_steps, cmd_stop_on_ovf, abort, done_ready,
      input  cmd_ready, done_valid, done_status, done_count
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_steps, cmd_stop_on_ovf, abort, done_ready,
      output cmd_ready, done_valid, done_status, done_count
   );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencer that turns "count N steps" commands into en/up_down pulses for the
// up/down counter and reports a completion record with status and pulse count.
module counter_seq_ctrl #(
   parameter int CNT_W  = 4,
   parameter int STEP_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   counter_seq_ctrl_if.slave  bus,
   output logic               en,
   output logic               up_down,
   input  logic [CNT_W-1:0]   cnt_i,
   input  logic               overflow_i,
   output logic               busy
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_RESP
   } state_t;

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_OVF_STOP = 2'b10;
   localparam logic [1:0] ST_ABORTED  = 2'b11;

   state_t            state_q;
   logic              en_q;
   logic              up_down_q;
   logic              done_valid_q;
   logic [1:0]        done_status_q;
   logic [STEP_W-1:0] done_count_q;
   logic [STEP_W-1:0] steps_q;
   logic [STEP_W-1:0] issued_q;
   logic [STEP_W-1:0] issued_d;
   logic              stop_q;
   logic              ovf_seen_q;
   logic              ovf_seen_d;
   // term_q holds the early-exit status code; ST_OK means the run ended normally.
   logic [1:0]        term_q;
   logic [1:0]        status_d;

   // cnt_i is observation-only; the sequencer never steers on the count value.
   logic              unused_cnt;
   assign unused_cnt = ^cnt_i;

   assign issued_d   = issued_q + 1'b1;
   assign ovf_seen_d = ovf_seen_q | overflow_i;
   assign status_d   = (term_q != ST_OK) ? term_q : {1'b0, ovf_seen_d};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         en_q          <= 1'b0;
         up_down_q     <= 1'b0;
         done_valid_q  <= 1'b0;
         done_status_q <= ST_OK;
         done_count_q  <= '0;
         steps_q       <= '0;
         issued_q      <= '0;
         stop_q        <= 1'b0;
         ovf_seen_q    <= 1'b0;
         term_q        <= ST_OK;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  steps_q    <= bus.cmd_steps;
                  stop_q     <= bus.cmd_stop_on_ovf;
                  ovf_seen_q <= 1'b0;
                  term_q     <= ST_OK;
                  if (bus.cmd_steps == '0) begin
                     state_q       <= S_RESP;
                     issued_q      <= '0;
                     done_valid_q  <= 1'b1;
                     done_status_q <= ST_OK;
                     done_count_q  <= '0;
                  end else begin
                     // issued_q counts the pulse being driven in the current cycle
                     state_q   <= S_RUN;
                     issued_q  <= {{(STEP_W-1){1'b0}}, 1'b1};
                     en_q      <= 1'b1;
                     up_down_q <= bus.cmd_dir;
                  end
               end
            end
            S_RUN: begin
               ovf_seen_q <= ovf_seen_d;
               if (bus.abort) begin
                  en_q    <= 1'b0;
                  term_q  <= ST_ABORTED;
                  state_q <= S_DRAIN;
               end else if (overflow_i && stop_q) begin
                  en_q    <= 1'b0;
                  term_q  <= ST_OVF_STOP;
                  state_q <= S_DRAIN;
               end else if (issued_q == steps_q) begin
                  en_q    <= 1'b0;
                  state_q <= S_DRAIN;
               end else begin
                  issued_q <= issued_d;
               end
            end
            S_DRAIN: begin
               // the overflow of the final pulse lands here and still counts
               ovf_seen_q    <= ovf_seen_d;
               done_valid_q  <= 1'b1;
               done_status_q <= status_d;
               done_count_q  <= issued_q;
               state_q       <= S_RESP;
            end
            S_RESP: begin
               if (bus.done_ready) begin
                  done_valid_q <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready   = (state_q == S_IDLE) && !rst;
   assign bus.done_valid  = done_valid_q;
   assign bus.done_status = done_status_q;
   assign bus.done_count  = done_count_q;
   assign en              = en_q;
   assign up_down         = up_down_q;
   assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Randomised bench for counter_seq_ctrl with a 4-bit wrapping counter model
// and a pulse-level reference model of the command outcome.
module tb_counter_seq_ctrl;
   localparam int BIG = 1 << 30;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   counter_seq_ctrl_if #(.STEP_W(8)) bus();
   logic       en, up_down, busy;
   logic [3:0] cnt_m;
   logic       ovf_m;
   logic       load_req;
   logic [3:0] load_val;

   counter_seq_ctrl #(.CNT_W(4), .STEP_W(8)) dut (
      .clk(clk), .rst(rst), .bus(bus), .en(en), .up_down(up_down),
      .cnt_i(cnt_m), .overflow_i(ovf_m), .busy(busy)
   );

   // counter datapath: overflow pulse one cycle after the wrapping en pulse
   always @(posedge clk) begin
      if (load_req) begin
         cnt_m <= load_val;
         ovf_m <= 1'b0;
      end else begin
         ovf_m <= en && (up_down ? (cnt_m == 4'd15) : (cnt_m == 4'd0));
         if (en) cnt_m <= up_down ? cnt_m + 4'd1 : cnt_m - 4'd1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;
   int en_lo = 1, en_hi = 0, dv_lo = 1, dv_hi = 0, bs_lo = 1, bs_hi = 0;
   int exp_st, exp_cnt;
   bit exp_dir;
   int model_cnt = 0;
   int last_acc = 0;
   int first_dv = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // outcome of one command, stepping pulse by pulse through the counter values
   function automatic void predict(input int start, input bit dir, input int steps, input bit stop,
                                   input int abort_k, output int n, output int st, output int ec);
      int c;
      bit w, wprev, any;
      c = start; n = 0; st = 0; any = 0; wprev = 0;
      for (int k = 1; k <= steps; k++) begin
         w = dir ? (c == 15) : (c == 0);
         c = dir ? (c + 1) % 16 : (c + 15) % 16;
         any = any | w;
         n = k;
         if (abort_k == k) begin st = 3; break; end
         if (stop && wprev) begin st = 2; break; end
         wprev = w;
      end
      if (st == 0 && any) st = 1;
      ec = c;
   endfunction

   always @(negedge clk) begin
      #2;
      if (chk_on) begin
         bit e_en, e_dv, e_bs;
         e_en = (cyc >= en_lo) && (cyc <= en_hi);
         e_dv = (cyc >= dv_lo) && (cyc <= dv_hi);
         e_bs = (cyc >= bs_lo) && (cyc <= bs_hi);
         check("en", en, e_en);
         check("done_valid", bus.done_valid, e_dv);
         check("busy", busy, e_bs);
         check("cmd_ready", bus.cmd_ready, !rst && !e_bs);
         if (e_en) check("up_down", up_down, exp_dir);
         if (e_dv) begin
            check("done_status", bus.done_status, exp_st);
            check("done_count", bus.done_count, exp_cnt);
         end
      end
   end

   task automatic load_cnt(input logic [3:0] v);
      @(negedge clk);
      load_req = 1'b1;
      load_val = v;
      @(negedge clk);
      load_req = 1'b0;
      model_cnt = int'(v);
   endtask

   task automatic run_cmd(input bit dir, input int steps, input bit stop, input int abort_k,
                          input int rdy_dly, input int rst_at);
      int n, st, ec, acc, guard, dly;
      bit done;
      predict(model_cnt, dir, steps, stop, abort_k, n, st, ec);
      guard = 0;
      @(negedge clk);
      while (!bus.cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.cmd_ready) begin
         check("cmd_ready_timeout", 0, 1);
         return;
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_dir = dir;
      bus.cmd_steps = steps[7:0];
      bus.cmd_stop_on_ovf = stop;
      acc = cyc + 1;
      last_acc = acc;
      en_lo = acc; en_hi = acc + n - 1;
      dv_lo = (steps == 0) ? acc : acc + n + 1; dv_hi = BIG;
      bs_lo = acc; bs_hi = BIG;
      exp_st = st; exp_cnt = n; exp_dir = dir;
      first_dv = -1;
      dly = rdy_dly;
      done = 1'b0;
      for (int k = 0; k < steps + rdy_dly + 20 && !done; k++) begin
         @(negedge clk);
         bus.cmd_valid = 1'($urandom_range(0, 1));
         bus.cmd_dir = 1'($urandom_range(0, 1));
         bus.cmd_steps = 8'($urandom);
         bus.cmd_stop_on_ovf = 1'($urandom_range(0, 1));
         bus.abort = (abort_k > 0) && (cyc == acc + abort_k - 1);
         bus.done_ready = 1'b0;
         if (rst_at > 0 && cyc == acc + rst_at - 1) begin
            rst = 1'b1;
            if (en_hi > cyc) en_hi = cyc;
            dv_hi = cyc;
            bs_hi = cyc;
            done = 1'b1;
         end else if (bus.done_valid) begin
            if (first_dv < 0) first_dv = cyc;
            if (dly == 0) begin
               bus.done_ready = 1'b1;
               bus.cmd_valid = 1'b0;
               dv_hi = cyc;
               bs_hi = cyc;
               done = 1'b1;
            end else begin
               dly--;
            end
         end
      end
      if (!done) begin
         check("done_timeout", 0, 1);
         rst = 1'b1;
         en_hi = cyc; dv_hi = cyc; bs_hi = cyc;
      end
      @(negedge clk);
      bus.done_ready = 1'b0;
      bus.abort = 1'b0;
      bus.cmd_valid = 1'b0;
      if (rst_at > 0 && done) begin
         check("rst_en", en, 0);
         check("rst_busy", busy, 0);
         check("rst_done_valid", bus.done_valid, 0);
         model_cnt = dir ? (model_cnt + rst_at) % 16 : (model_cnt + 16 * 16 - rst_at) % 16;
      end else if (done) begin
         model_cnt = ec;
         check("cnt_after", cnt_m, ec);
      end
      rst = 1'b0;
   endtask

   initial begin
      int n, st, ec;
      rst = 1'b1;
      load_req = 1'b1;
      load_val = 4'd0;
      bus.cmd_valid = 1'b0;
      bus.cmd_dir = 1'b0;
      bus.cmd_steps = 8'd0;
      bus.cmd_stop_on_ovf = 1'b0;
      bus.abort = 1'b0;
      bus.done_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      @(negedge clk);
      check("reset_en", en, 0);
      check("reset_up_down", up_down, 0);
      check("reset_done_valid", bus.done_valid, 0);
      check("reset_done_status", bus.done_status, 0);
      check("reset_done_count", bus.done_count, 0);
      check("reset_cmd_ready", bus.cmd_ready, 0);
      check("reset_busy", busy, 0);
      rst = 1'b0;
      load_req = 1'b0;

      predict(0, 1, 5, 0, 0, n, st, ec);
      check("pin1_n", n, 5); check("pin1_st", st, 0); check("pin1_cnt", ec, 5);
      load_cnt(4'd0);
      run_cmd(1, 5, 0, 0, 0, 0);
      check("t1_cnt", cnt_m, 5);
      check("t1_latency", first_dv - last_acc, 6);

      predict(0, 1, 20, 0, 0, n, st, ec);
      check("pin2_n", n, 20); check("pin2_st", st, 1); check("pin2_cnt", ec, 4);
      load_cnt(4'd0);
      run_cmd(1, 20, 0, 0, 1, 0);
      check("t2_cnt", cnt_m, 4);

      predict(14, 1, 10, 1, 0, n, st, ec);
      check("pin3_n", n, 3); check("pin3_st", st, 2); check("pin3_cnt", ec, 1);
      load_cnt(4'd14);
      run_cmd(1, 10, 1, 0, 0, 0);
      check("t3_cnt", cnt_m, 1);

      run_cmd(1, 0, 0, 0, 0, 0);
      check("t4_zero_latency", first_dv - last_acc, 0);
      predict(0, 0, 1, 0, 0, n, st, ec);
      check("pin4_st", st, 1); check("pin4_cnt", ec, 15);
      load_cnt(4'd0);
      run_cmd(0, 1, 0, 0, 0, 0);
      check("t4_cnt", cnt_m, 15);

      predict(0, 1, 8, 0, 4, n, st, ec);
      check("pin5_n", n, 4); check("pin5_st", st, 3);
      load_cnt(4'd0);
      run_cmd(1, 8, 0, 4, 0, 0);
      check("t5_cnt", cnt_m, 4);
      predict(14, 1, 10, 1, 3, n, st, ec);
      check("pin5b_n", n, 3); check("pin5b_st", st, 3);
      load_cnt(4'd14);
      run_cmd(1, 10, 1, 3, 2, 0);

      load_cnt(4'd0);
      run_cmd(1, 3, 0, 0, 5, 0);
      load_cnt(4'd0);
      run_cmd(1, 10, 0, 0, 0, 3);
      check("t6_cnt_after_rst", cnt_m, 3);
      repeat (4) @(negedge clk);

      predict(0, 1, 255, 0, 0, n, st, ec);
      check("pin7_n", n, 255); check("pin7_st", st, 1); check("pin7_cnt", ec, 15);
      load_cnt(4'd0);
      run_cmd(1, 255, 0, 0, 0, 0);

      for (int i = 0; i < 60; i++) begin
         int steps, ab;
         bit d, s;
         if ($urandom_range(0, 3) == 0) load_cnt(4'($urandom));
         d = 1'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 1));
         steps = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 35));
         ab = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, steps + 3));
         run_cmd(d, steps, s, ab, int'($urandom_range(0, 4)), 0);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
